// File: rtl/instruction_pkg.sv
// Shared types for the instruction fetch unit.
// Fetch FSM states, instruction size and the prefetch entry layout.
package instruction_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; flush wins over push in the same cycle.
// Ports: clk, reset, push/wdata, pop/rdata, flush, empty, count.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CW'(DEPTH));
    assign do_pop  = pop && (cnt != '0);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, outstanding/discard counters, halt FSM.
// Ports: imem req/gnt/rvalid bus, redirect_*, halt_i/halted_o, inst_v_o/inst_o/pc_o.
module fetch_unit
    import instruction_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        halted_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occupancy;
    logic          fire;
    logic          drop;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [63:0]   fifo_rdata;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign target    = {redirect_pc_i[31:2], 2'b00};
    assign occupancy = {1'b0, fifo_cnt} + {1'b0, outst};

    // Every granted request owns a FIFO slot, so the FIFO cannot overflow.
    assign imem_req  = !reset && (state == RUN) && !halt_i
                     && !redirect_v_i && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign drop      = imem_rvalid && ((discard != '0) || redirect_v_i);
    assign fifo_push = imem_rvalid && !drop;

    // The kill is combinational so the slot after a taken branch never issues.
    assign inst_v_o  = !fifo_empty && !redirect_v_i;
    assign fifo_pop  = inst_v_o;
    assign head      = fifo_rdata;
    assign inst_o    = head.inst;
    assign pc_o      = head.pc;
    assign halted_o  = (state == HALTED);

    assign wr_entry.pc   = resp_pc;
    assign wr_entry.inst = imem_rdata;

    always_comb begin
        outst_next = outst;
        if (fire && !imem_rvalid) outst_next = outst + CW'(1);
        if (!fire && imem_rvalid && outst != '0) outst_next = outst - CW'(1);
    end

    // Halted means nothing is left in flight once this cycle retires.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (halt_i) state_next = DRAIN;
            DRAIN:   if (!halt_i) state_next = RUN;
                     else if (outst_next == '0) state_next = HALTED;
            HALTED:  if (!halt_i) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            state <= state_next;
            outst <= outst_next;
            if (redirect_v_i) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= (imem_rvalid && outst != '0) ? outst - CW'(1) : outst;
            end else begin
                if (fire) fetch_pc <= fetch_pc + 32'(INST_BYTES);
                if (fifo_push) resp_pc <= resp_pc + 32'(INST_BYTES);
                if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .flush (redirect_v_i),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order variable-latency memory.
// Directed phases: stream, halt, branch, backpressure, redirect+rvalid, wrap.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_v_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        halted_o;
    logic        inst_v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          lat;
    int          first_v;
    int          last_v;
    pend_t       pend[$];
    logic [31:0] exp_q[$];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .halted_o      (halted_o),
        .inst_v_o      (inst_v_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (halted_o !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 60) begin
            miscompares++;
            $display("FAIL %s_halt_timeout: actual halted_o=%b required 1", name, halted_o);
        end
        repeat (3) step();
        check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Memory model: responses in request order, each after its latency.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            cyc = 1;
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            cyc = cyc + 1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: records grants, bounds occupancy, scores deliveries.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
            vectors++;
            if (int'(dut.fifo_cnt) + int'(dut.outst) > DEPTH) begin
                miscompares++;
                $display("FAIL occupancy: actual %0d required <= %0d",
                         int'(dut.fifo_cnt) + int'(dut.outst), DEPTH);
            end
            if (inst_v_o) begin
                if (first_v == 0) first_v = cyc;
                last_v = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_inst: actual pc %h required none", pc_o);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("deliver_pc", pc_o, e);
                    check("deliver_inst", inst_o, mem_word(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; lat = 1;
        first_v = 0; last_v = 0; cyc = 0;
        reset = 1'b1; halt_i = 1'b0; imem_gnt = 1'b1;
        redirect_v_i = 1'b0; redirect_pc_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("rst_req", {31'h0, imem_req}, 32'd0);
            check("rst_inst_v", {31'h0, inst_v_o}, 32'd0);
            check("rst_halted", {31'h0, halted_o}, 32'd0);
        end

        // T1: stream ten words at latency 1, then halt.
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        check("t1_req", {31'h0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        repeat (10) step();
        halt_i = 1'b1;
        wait_idle("t1");
        check("t1_first_valid_cycle", 32'(first_v), 32'd3);
        check("t1_last_valid_cycle", 32'(last_v), 32'd12);

        // T5: three outstanding at latency 4, then halt and resume.
        lat = 4;
        halt_i = 1'b0;
        exp_q.push_back(32'h28);
        exp_q.push_back(32'h2C);
        exp_q.push_back(32'h30);
        exp_q.push_back(32'h34);
        repeat (4) step();
        halt_i = 1'b1;
        @(negedge clk);
        check("t5_no_req", {31'h0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t5_not_halted", {31'h0, halted_o}, 32'd0);
        end
        step();
        @(negedge clk);
        check("t5_halted", {31'h0, halted_o}, 32'd1);
        step();
        halt_i = 1'b0;
        @(negedge clk);
        check("t5_still_stopped", {31'h0, imem_req}, 32'd0);
        step();
        @(negedge clk);
        check("t5_resume_req", {31'h0, imem_req}, 32'd1);
        check("t5_resume_addr", imem_addr, 32'h34);
        step();
        halt_i = 1'b1;
        wait_idle("t5");

        // T2: taken branch with two in flight and one buffered word.
        lat = 3;
        halt_i = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        step();
        step();
        imem_gnt = 1'b0;
        step();
        imem_gnt = 1'b1;
        step();
        step();
        redirect_v_i = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk);
        check("t2_kill", {31'h0, inst_v_o}, 32'd0);
        check("t2_no_req", {31'h0, imem_req}, 32'd0);
        step();
        redirect_v_i = 1'b0;
        @(negedge clk);
        check("t2_target_addr", imem_addr, 32'h100);
        repeat (3) step();
        halt_i = 1'b1;
        wait_idle("t2");

        // T3: ten cycles without grant, then fill to the limit.
        lat = 8;
        imem_gnt = 1'b0;
        halt_i = 1'b0;
        exp_q.push_back(32'h10C);
        exp_q.push_back(32'h110);
        exp_q.push_back(32'h114);
        exp_q.push_back(32'h118);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("t3_req_held", {31'h0, imem_req}, 32'd1);
            check("t3_addr_held", imem_addr, 32'h10C);
        end
        step();
        imem_gnt = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t3_full_no_req", {31'h0, imem_req}, 32'd0);
        step();
        halt_i = 1'b1;
        wait_idle("t3");

        // T4: redirect in the same cycle as the only response.
        lat = 2;
        halt_i = 1'b0;
        exp_q.push_back(32'h200);
        step();
        step();
        imem_gnt = 1'b0;
        step();
        redirect_v_i = 1'b1;
        redirect_pc_i = 32'h200;
        @(negedge clk);
        check("t4_kill", {31'h0, inst_v_o}, 32'd0);
        check("t4_no_req", {31'h0, imem_req}, 32'd0);
        step();
        redirect_v_i = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check("t4_req", {31'h0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h200);
        step();
        halt_i = 1'b1;
        wait_idle("t4");

        // T6: wrap past 2^32, then a misaligned target.
        lat = 1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        step();
        redirect_v_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_v_i = 1'b0;
        @(negedge clk);
        check("t6_halted_kept", {31'h0, halted_o}, 32'd1);
        step();
        halt_i = 1'b0;
        step();
        @(negedge clk);
        check("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("t6_wrapped_addr", imem_addr, 32'h0);
        step();
        halt_i = 1'b1;
        wait_idle("t6a");
        exp_q.push_back(32'h100);
        redirect_v_i = 1'b1;
        redirect_pc_i = 32'h103;
        step();
        redirect_v_i = 1'b0;
        halt_i = 1'b0;
        step();
        @(negedge clk);
        check("t6_align_req", {31'h0, imem_req}, 32'd1);
        check("t6_align_addr", imem_addr, 32'h100);
        step();
        halt_i = 1'b1;
        wait_idle("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
